// File: rtl/sample_pack_fifo_if.sv
// Handshake bundle for the sample packing FIFO: narrow write side, wide read side.
interface sample_pack_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PACK  = 10,
  parameter int unsigned DEPTH = 10
);

  // Write side
  logic                       wr_en;
  logic [WIDTH-1:0]           din;
  logic                       flush;
  logic                       full;
  logic                       almost_full;
  logic                       overflow;

  // Read side
  logic                       rd_en;
  logic [WIDTH*PACK-1:0]      dout;
  logic [$clog2(PACK+1)-1:0]  dout_lanes;
  logic                       dout_valid;
  logic                       empty;
  logic                       almost_empty;
  logic                       underflow;
  logic [$clog2(DEPTH+1)-1:0] count;

  // Producer/consumer side
  modport master (
    output wr_en, din, flush, rd_en,
    input  full, almost_full, overflow,
    input  dout, dout_lanes, dout_valid, empty, almost_empty, underflow, count
  );

  // FIFO side
  modport slave (
    input  wr_en, din, flush, rd_en,
    output full, almost_full, overflow,
    output dout, dout_lanes, dout_valid, empty, almost_empty, underflow, count
  );

endinterface

// File: rtl/sample_pack_fifo.sv
// Width-converting FIFO: packs PACK narrow samples into one wide word and queues
// wide words in a DEPTH-entry FIFO. Partial words can be flushed with a lane count.
module sample_pack_fifo #(
  parameter int unsigned WIDTH               = 8,
  parameter int unsigned PACK                = 10,
  parameter int unsigned DEPTH               = 10,
  parameter int unsigned ALMOST_FULL_THRESH  = DEPTH - 2,
  parameter int unsigned ALMOST_EMPTY_THRESH = 2
) (
  input logic               clk,
  input logic               reset,
  sample_pack_fifo_if.slave bus
);

  localparam int unsigned WordW    = WIDTH * PACK;
  localparam int unsigned LaneW    = $clog2(PACK + 1);
  localparam int unsigned CntW     = $clog2(DEPTH + 1);
  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned PackCntW = $clog2(PACK);

  localparam logic [CntW-1:0]     DepthC   = CntW'(DEPTH);
  localparam logic [PtrW-1:0]     PtrLast  = PtrW'(DEPTH - 1);
  localparam logic [PackCntW-1:0] PackLast = PackCntW'(PACK - 1);
  localparam logic [LaneW-1:0]    LanesAll = LaneW'(PACK);

  // Packer state
  logic [PackCntW-1:0] pack_cnt_q, pack_cnt_d;
  logic [WordW-1:0]    pack_buf_q, pack_buf_d;
  logic                flush_pend_q, flush_pend_d;

  // FIFO state
  logic [WordW-1:0]    mem_q       [DEPTH];
  logic [LaneW-1:0]    mem_lanes_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;

  // Registered read port and error pulses
  logic [WordW-1:0]    dout_q;
  logic [LaneW-1:0]    dout_lanes_q;
  logic                dout_valid_q;
  logic                overflow_q;
  logic                underflow_q;

  // Decoded control
  logic                full_c;
  logic                empty_c;
  logic                last_lane;
  logic                wr_acc;
  logic                rd_acc;
  logic                push_full;
  logic                push_flush;
  logic                push;
  logic [WordW-1:0]    word_merged;
  logic [WordW-1:0]    push_word;
  logic [LaneW-1:0]    push_lanes;

  // Handshake decode; a pending flush blocks writes until its partial word is pushed
  always_comb begin
    last_lane  = (pack_cnt_q == PackLast);
    full_c     = flush_pend_q | ((count_q == DepthC) & last_lane);
    empty_c    = (count_q == '0);
    wr_acc     = bus.wr_en & ~full_c;
    rd_acc     = bus.rd_en & ~empty_c;
    // full_c guarantees count < DEPTH whenever the final lane is accepted
    push_full  = wr_acc & last_lane;
    push_flush = flush_pend_q & (count_q != DepthC);
    push       = push_full | push_flush;
  end

  // Current buffer with din dropped into lane pack_cnt
  always_comb begin
    word_merged = pack_buf_q;
    for (int unsigned l = 0; l < PACK; l++) begin
      if (pack_cnt_q == PackCntW'(l)) begin
        word_merged[l*WIDTH +: WIDTH] = bus.din;
      end
    end
  end

  // Select what gets written into the FIFO on a push
  always_comb begin
    if (push_full) begin
      push_word  = word_merged;
      push_lanes = LanesAll;
    end else begin
      // Buffer is cleared at each word start, so unused upper lanes are already zero
      push_word  = pack_buf_q;
      push_lanes = LaneW'(pack_cnt_q);
    end
  end

  // Packer next state: lane counter, partial buffer and flush request
  always_comb begin
    pack_cnt_d   = pack_cnt_q;
    pack_buf_d   = pack_buf_q;
    flush_pend_d = flush_pend_q;
    if (push_flush) begin
      pack_cnt_d   = '0;
      pack_buf_d   = '0;
      flush_pend_d = 1'b0;
    end else if (wr_acc) begin
      if (last_lane) begin
        // Completed word goes out as a normal push; any same-cycle flush has nothing left
        pack_cnt_d = '0;
        pack_buf_d = '0;
      end else begin
        pack_cnt_d = pack_cnt_q + 1'b1;
        pack_buf_d = word_merged;
        if (bus.flush) begin
          flush_pend_d = 1'b1;
        end
      end
    end else if (bus.flush && !flush_pend_q && (pack_cnt_q != '0)) begin
      flush_pend_d = 1'b1;
    end
  end

  // FIFO pointer and occupancy next state; no read bypass of a same-cycle push
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Packer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pack_cnt_q   <= '0;
      pack_buf_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      pack_cnt_q   <= pack_cnt_d;
      pack_buf_q   <= pack_buf_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // FIFO pointers and count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]       <= push_word;
      mem_lanes_q[wr_ptr_q] <= push_lanes;
    end
  end

  // Registered read port (dout holds between reads) and one-cycle error pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q       <= '0;
      dout_lanes_q <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      dout_valid_q <= rd_acc;
      overflow_q   <= bus.wr_en & full_c;
      underflow_q  <= bus.rd_en & empty_c;
      if (rd_acc) begin
        dout_q       <= mem_q[rd_ptr_q];
        dout_lanes_q <= mem_lanes_q[rd_ptr_q];
      end
    end
  end

  assign bus.full         = full_c;
  assign bus.almost_full  = (32'(count_q) >= ALMOST_FULL_THRESH);
  assign bus.overflow     = overflow_q;
  assign bus.dout         = dout_q;
  assign bus.dout_lanes   = dout_lanes_q;
  assign bus.dout_valid   = dout_valid_q;
  assign bus.empty        = empty_c;
  assign bus.almost_empty = (32'(count_q) <= ALMOST_EMPTY_THRESH);
  assign bus.underflow    = underflow_q;
  assign bus.count        = count_q;

endmodule

// File: tb/tb_sample_pack_fifo.sv
// Self-checking bench for sample_pack_fifo with WIDTH=8, PACK=4, DEPTH=3.
module tb_sample_pack_fifo;

  localparam int unsigned W = 8;
  localparam int unsigned P = 4;
  localparam int unsigned D = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sample_pack_fifo_if #(.WIDTH(W), .PACK(P), .DEPTH(D)) bus ();

  sample_pack_fifo #(
    .WIDTH              (W),
    .PACK               (P),
    .DEPTH              (D),
    .ALMOST_FULL_THRESH (2),
    .ALMOST_EMPTY_THRESH(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Expected read words: {lanes[2:0], word[31:0]}
  logic [34:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] lanes, input logic [31:0] word);
    sb_q.push_back({lanes, word});
  endtask

  // Apply inputs for exactly one rising edge, return 1 time unit after it
  task automatic step(input logic wr, input logic [7:0] d, input logic fl, input logic rd);
    bus.wr_en = wr;
    bus.din   = d;
    bus.flush = fl;
    bus.rd_en = rd;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.flush = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Scoreboard: every valid read word must match the oldest expected entry.
  // An unexpected word is compared against an impossible lane count of 7.
  always @(negedge clk) begin
    logic [34:0] exp;
    if (bus.dout_valid === 1'b1) begin
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
      check_eq("sb_word", {29'b0, bus.dout_lanes, bus.dout}, {29'b0, exp});
    end
  end

  initial begin
    logic [31:0] w;
    reset     = 1'b1;
    bus.wr_en = 1'b0;
    bus.din   = '0;
    bus.flush = 1'b0;
    bus.rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_empty", bus.empty, 1);
    check_eq("rst_almost_empty", bus.almost_empty, 1);
    check_eq("rst_full", bus.full, 0);
    check_eq("rst_almost_full", bus.almost_full, 0);
    check_eq("rst_count", bus.count, 0);
    check_eq("rst_dout_valid", bus.dout_valid, 0);
    reset = 1'b0;

    // Pack and read
    wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
    check_eq("pack_count1", bus.count, 1);
    push_exp(3'd4, 32'h04030201);
    rd();
    check_eq("pack_dout_valid", bus.dout_valid, 1);
    check_eq("pack_dout_lanes", bus.dout_lanes, 4);
    check_eq("pack_dout", bus.dout, 32'h04030201);
    check_eq("pack_count0", bus.count, 0);
    check_eq("pack_empty", bus.empty, 1);
    idle();
    check_eq("pack_valid_pulse", bus.dout_valid, 0);

    // Fill and full
    for (int i = 0; i < 12; i++) wr(8'(8'h10 + i));
    push_exp(3'd4, 32'h13121110);
    push_exp(3'd4, 32'h17161514);
    push_exp(3'd4, 32'h1B1A1918);
    check_eq("fill_count", bus.count, 3);
    check_eq("fill_almost_full", bus.almost_full, 1);
    check_eq("fill_almost_empty", bus.almost_empty, 0);
    check_eq("fill_full_lane0", bus.full, 0);
    wr(8'h20); wr(8'h21); wr(8'h22);
    check_eq("fill_full_lane3", bus.full, 1);
    wr(8'h23);
    check_eq("fill_overflow", bus.overflow, 1);
    check_eq("fill_count_held", bus.count, 3);
    idle();
    check_eq("fill_overflow_pulse", bus.overflow, 0);
    rd();
    check_eq("fill_full_drop", bus.full, 0);
    check_eq("fill_count_after_rd", bus.count, 2);
    rd(); rd();
    check_eq("fill_almost_empty_low", bus.almost_empty, 1);
    wr(8'h23);
    push_exp(3'd4, 32'h23222120);
    rd();

    // Wrap-around: continuous writes with a read every fourth cycle
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'(8'h40 + 4*g + k);
      push_exp(3'd4, w);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(8'h40 + i), 1'b0, (i % 4 == 0) && (i > 0));
      check_eq($sformatf("wrap_count_%0d", i), bus.count, (i % 4 == 3) ? 1 : 0);
    end
    rd();
    check_eq("wrap_drained", bus.count, 0);

    // Flush partial
    wr(8'hAA); wr(8'hBB);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("flush_pend_full", bus.full, 1);
    push_exp(3'd2, 32'h0000BBAA);
    idle();
    check_eq("flush_count", bus.count, 1);
    check_eq("flush_full_clear", bus.full, 0);
    rd();
    check_eq("flush_lanes", bus.dout_lanes, 2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    idle();
    check_eq("flush_noop_count", bus.count, 0);
    check_eq("flush_noop_full", bus.full, 0);
    step(1'b1, 8'hCC, 1'b1, 1'b0);
    push_exp(3'd1, 32'h000000CC);
    idle();
    check_eq("flush_wr_same_count", bus.count, 1);
    rd();

    // Flush blocked by a full FIFO
    for (int i = 0; i < 12; i++) wr(8'(8'h50 + i));
    push_exp(3'd4, 32'h53525150);
    push_exp(3'd4, 32'h57565554);
    push_exp(3'd4, 32'h5B5A5958);
    wr(8'h60);
    check_eq("blk_full_lane1", bus.full, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("blk_full_pend", bus.full, 1);
    idle();
    check_eq("blk_full_held", bus.full, 1);
    check_eq("blk_count_held", bus.count, 3);
    push_exp(3'd1, 32'h00000060);
    rd();
    check_eq("blk_count_rd", bus.count, 2);
    check_eq("blk_full_still", bus.full, 1);
    idle();
    check_eq("blk_count_push", bus.count, 3);
    check_eq("blk_full_drop", bus.full, 0);
    rd(); rd(); rd();
    check_eq("blk_drained", bus.count, 0);

    // Underflow and mid-operation reset
    rd();
    check_eq("unf_pulse", bus.underflow, 1);
    check_eq("unf_no_valid", bus.dout_valid, 0);
    idle();
    check_eq("unf_pulse_end", bus.underflow, 0);
    for (int i = 0; i < 11; i++) wr(8'(8'h80 + i));
    check_eq("mid_count2", bus.count, 2);
    #3 reset = 1'b1;
    #1;
    check_eq("mid_rst_count", bus.count, 0);
    check_eq("mid_rst_empty", bus.empty, 1);
    check_eq("mid_rst_almost_empty", bus.almost_empty, 1);
    check_eq("mid_rst_full", bus.full, 0);
    check_eq("mid_rst_almost_full", bus.almost_full, 0);
    check_eq("mid_rst_dout", bus.dout, 0);
    check_eq("mid_rst_lanes", bus.dout_lanes, 0);
    check_eq("mid_rst_valid", bus.dout_valid, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    // Partial word from before reset must be gone
    wr(8'h70); wr(8'h71); wr(8'h72); wr(8'h73);
    push_exp(3'd4, 32'h73727170);
    rd();
    idle();
    idle();
    check_eq("sb_drain", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_pack_fifo.md
Name: sample_pack_fifo

Overview:
- Width-converting FIFO for the sweeper/PLL sample path. PACK narrow samples are packed into one wide word, which is queued in a DEPTH-entry wide FIFO.
- The read side pops one full packed word per accepted read.
- Adds features the earlier FIFO lacked:
  - correct lane packing with a non-power-of-2 DEPTH wrap;
  - flush of a partially filled word, with a valid-lane count;
  - a registered output valid;
  - overflow and underflow pulses.

Parameters:
- WIDTH, 8: narrow sample width (bits).
- PACK, 10: narrow samples per wide word (>=2).
- DEPTH, 10: wide-word FIFO entries (>=2, any integer).
- ALMOST_FULL_THRESH, DEPTH-2: almost_full when count >= this.
- ALMOST_EMPTY_THRESH, 2: almost_empty when count <= this.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write one narrow sample.
- din  in  WIDTH  narrow sample.
- flush  in  1  single-cycle request to push the partial word.
- full  out  1  a write this cycle would not be accepted.
- almost_full  out  1  count >= ALMOST_FULL_THRESH.
- overflow  out  1  one-cycle pulse when wr_en is asserted while full.
- rd_en  in  1  pop one wide word.
- dout  out  WIDTH*PACK  packed word; lane 0 (bits WIDTH-1:0) holds the oldest sample.
- dout_lanes  out  $clog2(PACK+1)  number of valid lanes in dout.
- dout_valid  out  1  dout/dout_lanes valid, one-cycle pulse.
- empty  out  1  count == 0.
- almost_empty  out  1  count <= ALMOST_EMPTY_THRESH.
- underflow  out  1  one-cycle pulse when rd_en is asserted while empty.
- count  out  $clog2(DEPTH+1)  wide words stored.

Behaviour:
Reset (async, active-high):
- Pointers, count, pack_cnt, flush_pend, dout, dout_lanes, dout_valid, overflow and underflow all go to 0.
- Resulting flags: empty=1, almost_empty=1, full=0, almost_full=(ALMOST_FULL_THRESH==0).
- Reset mid-operation discards the partial word and all stored data.

Packer:
- pack_cnt runs 0..PACK-1.
- An accepted write places din in lane pack_cnt.
- If pack_cnt<PACK-1: pack_cnt increments; no FIFO push.
- If pack_cnt==PACK-1: the full word (prior lanes plus din) is pushed with lanes=PACK, and pack_cnt returns to 0. This needs count<DEPTH.

full:
- full = flush_pend OR (count==DEPTH AND pack_cnt==PACK-1).
- Writes into a non-final lane are accepted even while the FIFO is full.

Flush:
- A flush with pack_cnt==0 and no same-cycle write is a no-op.
- Otherwise flush_pend is set.
- If wr_en and flush are accepted in the same cycle, din is included in the partial word before the flush.
- While flush_pend is set:
  - the partial word is pushed on the first cycle with count<DEPTH;
  - unused upper lanes are zero;
  - lanes equals the number of filled lanes;
  - pack_cnt returns to 0 and flush_pend clears.
- If the final-lane write completes the word, it is a normal push; flush then has nothing left to do.

FIFO storage:
- wr_ptr and rd_ptr wrap DEPTH-1 -> 0.
- Push requires the registered count<DEPTH. There is no same-cycle read bypass.
- An accepted read requires rd_en AND count>0.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- count never exceeds DEPTH and never goes below 0.

Read latency:
- On an accepted read at edge N, dout, dout_lanes and dout_valid=1 are registered at edge N.
- They are visible in the cycle after rd_en.
- dout holds its value when dout_valid=0.

Error pulses:
- overflow: wr_en&&full.
- underflow: rd_en&&empty.
- Both are registered, one cycle long, and have no state side effects.

Test Plan:
(Overrides WIDTH=8, PACK=4, DEPTH=3, thresholds 2/1.)
- Pack and read: reset, then write 0x01..0x04 and pulse rd_en -> the cycle after, dout=0x04030201, dout_lanes=4, dout_valid=1; count is 1 then 0; empty=1.
- Fill and full: write 12 samples -> count=3, almost_full=1, full=0 with pack_cnt=0. Write 3 more -> full=1. A 4th wr_en gives an overflow pulse, and later reads return only the first 3 words.
- Wrap-around: 5 cycles of interleaved push and pop (continuous writes plus periodic reads) -> words come out in order across the 2->0 pointer wrap; count never exceeds 3.
- Flush partial: write 0xAA,0xBB then pulse flush -> next word read gives dout=0x0000BBAA, dout_lanes=2. Flush with pack_cnt=0 -> count unchanged.
- Flush blocked: FIFO full and 1 lane pending, then flush -> full=1 held. Issue one read -> the partial word is pushed the next cycle, flush_pend clears, and full drops.
- Underflow and reset: rd_en on empty -> underflow pulse, dout_valid=0. Assert reset with count=2 and pack_cnt=3 -> all outputs return to reset values immediately.
